// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared defaults and types for the register file slice
package reg_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;
endpackage

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - control/datapath bundle between the control FSM and the register file
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              reg_dst;
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] mem_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] rd_data3;
    logic              rs_pending;
    logic              rt_pending;
    logic              stall;

    modport master (
        output rs_addr, rt_addr, rd_addr, reg_dst, reg_write, mem_to_reg,
               alu_data, mem_data, issue_valid, issue_addr,
        input  rd_data1, rd_data2, rd_data3, rs_pending, rt_pending, stall
    );

    modport slave (
        input  rs_addr, rt_addr, rd_addr, reg_dst, reg_write, mem_to_reg,
               alu_data, mem_data, issue_valid, issue_addr,
        output rd_data1, rd_data2, rd_data3, rs_pending, rt_pending, stall
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// rtl/reg_file_mp_scoreboard.sv - per-register pending bits; an issue beats a same-edge writeback
module reg_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_valid,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_valid,
    input  logic [ADDR_W-1:0]      clr_addr,
    output logic [(2**ADDR_W)-1:0] pend
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_valid) pend_d[clr_addr] = 1'b0;
        if (set_valid) pend_d[set_addr] = 1'b1;
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign pend = pend_q;
endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multicycle datapath register file: 2 read ports, dst read-back, 1 write port
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] wval;
    wb_src_e           wb_src;
    logic              wr_en;
    logic              fwd1;
    logic              fwd2;
    logic [DEPTH-1:0]  pend;

    always_comb begin
        wb_src = wb_src_e'(bus.mem_to_reg);
        dst    = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
        wval   = (wb_src == WB_MEM) ? bus.mem_data : bus.alu_data;
        wr_en  = bus.reg_write && !((ZERO_REG != 0) && (dst == ADDR_W'(ZERO_ADDR)));
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[dst] = wval;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_n) mem_q[i] <= '0;
            else        mem_q[i] <= mem_d[i];
        end
    end

    // wr_en already excludes the hardwired-zero destination, so it also gates forwarding
    always_comb begin
        fwd1 = (BYPASS != 0) && wr_en && (dst == bus.rs_addr);
        fwd2 = (BYPASS != 0) && wr_en && (dst == bus.rt_addr);

        bus.rd_data1 = mem_q[bus.rs_addr];
        if ((ZERO_REG != 0) && (bus.rs_addr == ADDR_W'(ZERO_ADDR))) bus.rd_data1 = '0;
        if (fwd1) bus.rd_data1 = wval;

        bus.rd_data2 = mem_q[bus.rt_addr];
        if ((ZERO_REG != 0) && (bus.rt_addr == ADDR_W'(ZERO_ADDR))) bus.rd_data2 = '0;
        if (fwd2) bus.rd_data2 = wval;

        bus.rd_data3 = mem_q[dst];
        if ((ZERO_REG != 0) && (dst == ADDR_W'(ZERO_ADDR))) bus.rd_data3 = '0;

        bus.rs_pending = pend[bus.rs_addr] && !fwd1;
        bus.rt_pending = pend[bus.rt_addr] && !fwd2;
        bus.stall      = bus.rs_pending || bus.rt_pending;
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (bus.issue_valid),
        .set_addr  (bus.issue_addr),
        .clr_valid (bus.reg_write),
        .clr_addr  (dst),
        .pend      (pend)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench driving bypass and non-bypass register files in lockstep
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]  s_rs, s_rt, s_rd, s_ia;
    logic        s_rdst, s_we, s_m2r, s_iv;
    logic [31:0] s_alu, s_mem;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) if_n ();

    assign if_b.rs_addr = s_rs;   assign if_n.rs_addr = s_rs;
    assign if_b.rt_addr = s_rt;   assign if_n.rt_addr = s_rt;
    assign if_b.rd_addr = s_rd;   assign if_n.rd_addr = s_rd;
    assign if_b.reg_dst = s_rdst; assign if_n.reg_dst = s_rdst;
    assign if_b.reg_write = s_we; assign if_n.reg_write = s_we;
    assign if_b.mem_to_reg = s_m2r; assign if_n.mem_to_reg = s_m2r;
    assign if_b.alu_data = s_alu; assign if_n.alu_data = s_alu;
    assign if_b.mem_data = s_mem; assign if_n.mem_data = s_mem;
    assign if_b.issue_valid = s_iv; assign if_n.issue_valid = s_iv;
    assign if_b.issue_addr = s_ia; assign if_n.issue_addr = s_ia;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));
    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(if_n));

    typedef struct {
        logic [31:0] r1_b, r2_b, r1_n, r2_n, r3;
        logic        p1_b, p2_b, p1_n, p2_n;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [32];
    bit          m_pend[32];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".rd1_byp"},   if_b.rd_data1, e.r1_b);
                chk({e.name, ".rd2_byp"},   if_b.rd_data2, e.r2_b);
                chk({e.name, ".rd3_byp"},   if_b.rd_data3, e.r3);
                chk({e.name, ".rsp_byp"},   32'(if_b.rs_pending), 32'(e.p1_b));
                chk({e.name, ".rtp_byp"},   32'(if_b.rt_pending), 32'(e.p2_b));
                chk({e.name, ".stall_byp"}, 32'(if_b.stall), 32'(e.p1_b | e.p2_b));
                chk({e.name, ".rd1_nob"},   if_n.rd_data1, e.r1_n);
                chk({e.name, ".rd2_nob"},   if_n.rd_data2, e.r2_n);
                chk({e.name, ".rd3_nob"},   if_n.rd_data3, e.r3);
                chk({e.name, ".stall_nob"}, 32'(if_n.stall), 32'(e.p1_n | e.p2_n));
            end
        end
    end

    // Drive one cycle of inputs (entered just after a rising edge), queue the
    // expected outputs, then advance the reference model across the next edge.
    task automatic cycle(input string name, input bit rstn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input bit rdst, input bit we, input bit m2r,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input bit iv, input logic [4:0] ia);
        exp_t        e;
        logic [4:0]  dst;
        logic [31:0] wv;
        bit          wr;
        rst_n = rstn; s_rs = rs; s_rt = rt; s_rd = rd; s_rdst = rdst; s_we = we;
        s_m2r = m2r; s_alu = alu; s_mem = mem; s_iv = iv; s_ia = ia;
        dst = rdst ? rd : rt;
        wv  = m2r ? mem : alu;
        wr  = we && (dst != 0);
        e.name = name;
        e.r1_n = m_mem[rs];
        e.r2_n = m_mem[rt];
        e.r3   = m_mem[dst];
        e.r1_b = (wr && dst == rs) ? wv : m_mem[rs];
        e.r2_b = (wr && dst == rt) ? wv : m_mem[rt];
        e.p1_n = m_pend[rs];
        e.p2_n = m_pend[rt];
        e.p1_b = m_pend[rs] && !(wr && dst == rs);
        e.p2_b = m_pend[rt] && !(wr && dst == rt);
        exp_q.push_back(e);
        @(posedge clk);
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
        end else begin
            if (wr) m_mem[dst] = wv;
            if (we) m_pend[dst] = 0;
            if (iv && ia != 0) m_pend[ia] = 1;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; s_rs = 0; s_rt = 0; s_rd = 0; s_rdst = 0; s_we = 0;
        s_m2r = 0; s_alu = 0; s_mem = 0; s_iv = 0; s_ia = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
        #1;
        cycle("reset_idle", 1, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        cycle("wr_r5",      1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 32'hDEADBEEF, 0, 1, 5'd2);
        cycle("rd_r5",      0, 5'd5, 5'd2, 5'd0, 0, 0, 0, 0, 0, 1, 5'd3);
        cycle("after_rst",  1, 5'd5, 5'd2, 5'd3, 1, 0, 0, 0, 0, 0, 0);
        cycle("wr_r3",      1, 5'd0, 5'd0, 5'd3, 1, 1, 0, 32'h12345678, 0, 0, 0);
        cycle("wr_r7_mem",  1, 5'd3, 5'd7, 5'd0, 0, 1, 1, 32'h1, 32'hCAFEF00D, 0, 0);
        cycle("rd_r7",      1, 5'd3, 5'd7, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        cycle("wr_r0",      1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 32'hFFFFFFFF, 0, 1, 5'd0);
        cycle("rd_r0",      1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 0);
        cycle("wr_r9_old",  1, 5'd0, 5'd0, 5'd9, 1, 1, 0, 32'h00000011, 0, 1, 5'd9);
        cycle("byp_r9",     1, 5'd9, 5'd9, 5'd9, 1, 1, 0, 32'hA5A5A5A5, 0, 0, 0);
        cycle("rd_r9",      1, 5'd9, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        cycle("issue_r4",   1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 5'd4);
        cycle("pend_r4",    1, 5'd1, 5'd4, 5'd0, 1, 0, 0, 0, 0, 0, 0);
        cycle("wb_r4",      1, 5'd4, 5'd4, 5'd4, 1, 1, 1, 0, 32'h44, 0, 0);
        cycle("clr_r4",     1, 5'd1, 5'd4, 5'd0, 1, 0, 0, 0, 0, 0, 0);
        cycle("issue_r6",   1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 5'd6);
        cycle("wb_iss_r6",  1, 5'd1, 5'd2, 5'd6, 1, 1, 0, 32'h66666666, 0, 1, 5'd6);
        cycle("pend_r6",    1, 5'd6, 5'd6, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            cycle("rand", ($urandom_range(0, 39) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7) + (($urandom_range(0, 9) == 0) ? 24 : 0)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 7)));
        end
        rst_n = 1'b1; s_we = 0; s_iv = 0;
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
